// File: rtl/board_engine.sv
// board_engine: 4x4 sliding-tile (2048-style) game engine with LFSR tile spawning.
// Define BOARD_ENGINE_SCORE_EN to build the saturating merge-score accumulator; otherwise score is 0.
module board_engine #(
    parameter logic [15:0] SEED    = 16'hACE1,
    parameter int unsigned WIN_EXP = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        move_valid,
    input  logic [1:0]  move_dir,
    output logic        move_ready,
    output logic [63:0] board,
    output logic        done,
    output logic [15:0] score,
    output logic        win,
    output logic        game_over
);

    typedef enum logic [2:0] {INIT, IDLE, SLIDE, SPAWN, CHECK, OVER} state_t;
    typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;
    // One line of four exponents; element 0 is the cell nearest the move direction.
    typedef logic [3:0][3:0] line_t;

    state_t      state, state_next;
    dir_t        dir_q, dir_next;
    logic [63:0] board_q, board_next;
    logic [15:0] lfsr, lfsr_next;
    logic [1:0]  line_cnt, line_cnt_next;
    logic        moved_q, moved_next;
    logic        init_cnt, init_cnt_next;
    logic        win_q, win_next;
    logic        over_q, over_next;

    logic [3:0]  cell_idx [4];
    line_t       line_in, line_out;
    logic        line_changed;

    function automatic logic [3:0] cell_index(input dir_t dir, input logic [1:0] line,
                                              input logic [1:0] pos);
        logic [1:0] row, col;
        case (dir)
            DIR_UP:   begin row = pos;         col = line;        end
            DIR_DOWN: begin row = 2'd3 - pos;  col = line;        end
            DIR_LEFT: begin row = line;        col = pos;         end
            default:  begin row = line;        col = 2'd3 - pos;  end
        endcase
        return {row, col};
    endfunction

    function automatic line_t compress(input line_t in);
        line_t      res;
        logic [2:0] n;
        res = '0;
        n   = '0;
        for (int i = 0; i < 4; i++) begin
            if (in[i] != 4'd0) begin
                res[n[1:0]] = in[i];
                n = n + 3'd1;
            end
        end
        return res;
    endfunction

    // Input is already compressed; a trailing zero sentinel keeps the pair compare in range.
    function automatic line_t merge(input line_t in);
        logic [4:0][3:0] ext;
        line_t           res;
        logic [2:0]      n;
        logic            skip;
        ext  = {4'd0, in};
        res  = '0;
        n    = '0;
        skip = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (skip) begin
                skip = 1'b0;
            end else if (ext[i] != 4'd0) begin
                if (ext[i] == ext[i+1]) begin
                    res[n[1:0]] = (ext[i] == 4'd15) ? 4'd15 : ext[i] + 4'd1;
                    skip = 1'b1;
                end else begin
                    res[n[1:0]] = ext[i];
                end
                n = n + 3'd1;
            end
        end
        return res;
    endfunction

    function automatic logic [63:0] spawn_tile(input logic [63:0] b, input logic [7:0] r);
        logic [63:0] res;
        logic        found;
        logic [3:0]  idx, hit;
        res   = b;
        found = 1'b0;
        hit   = '0;
        for (int k = 0; k < 16; k++) begin
            idx = r[3:0] + 4'(k);
            if (!found && b[{idx, 2'b00} +: 4] == 4'd0) begin
                found = 1'b1;
                hit   = idx;
            end
        end
        if (found) res[{hit, 2'b00} +: 4] = (r[7:4] == 4'd0) ? 4'd2 : 4'd1;
        return res;
    endfunction

    function automatic logic no_moves(input logic [63:0] b);
        logic stuck;
        stuck = 1'b1;
        for (int i = 0; i < 16; i++)
            if (b[i*4 +: 4] == 4'd0) stuck = 1'b0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (b[(r*4+c)*4 +: 4] == b[(r*4+c+1)*4 +: 4]) stuck = 1'b0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 4; c++)
                if (b[(r*4+c)*4 +: 4] == b[(r*4+c+4)*4 +: 4]) stuck = 1'b0;
        return stuck;
    endfunction

    function automatic logic has_win(input logic [63:0] b);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 16; i++)
            if (b[i*4 +: 4] >= 4'(WIN_EXP)) hit = 1'b1;
        return hit;
    endfunction

    // Fibonacci form of x^16+x^14+x^13+x^11+1, shifting right.
    assign lfsr_next = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            cell_idx[k] = cell_index(dir_q, line_cnt, 2'(k));
            line_in[k]  = board_q[{cell_idx[k], 2'b00} +: 4];
        end
        line_out     = merge(compress(line_in));
        line_changed = (line_out != line_in);
    end

    // NOTE: every variable is given a default first so no path through the case infers a latch.
    always_comb begin
        state_next    = state;
        board_next    = board_q;
        dir_next      = dir_q;
        line_cnt_next = line_cnt;
        moved_next    = moved_q;
        init_cnt_next = init_cnt;
        win_next      = win_q;
        over_next     = over_q;
        case (state)
            INIT: begin
                board_next    = spawn_tile(board_q, lfsr[7:0]);
                init_cnt_next = 1'b1;
                if (init_cnt) state_next = IDLE;
            end
            IDLE: begin
                if (move_valid) begin
                    dir_next      = dir_t'(move_dir);
                    line_cnt_next = 2'd0;
                    moved_next    = 1'b0;
                    state_next    = SLIDE;
                end
            end
            SLIDE: begin
                for (int k = 0; k < 4; k++)
                    board_next[{cell_idx[k], 2'b00} +: 4] = line_out[k];
                if (line_changed) moved_next = 1'b1;
                line_cnt_next = line_cnt + 2'd1;
                if (line_cnt == 2'd3) state_next = (moved_q || line_changed) ? SPAWN : CHECK;
            end
            SPAWN: begin
                board_next = spawn_tile(board_q, lfsr[7:0]);
                state_next = CHECK;
            end
            CHECK: begin
                if (has_win(board_q)) win_next = 1'b1;
                if (no_moves(board_q)) begin
                    over_next  = 1'b1;
                    state_next = OVER;
                end else begin
                    state_next = IDLE;
                end
            end
            OVER:    state_next = OVER;
            default: state_next = INIT;
        endcase
    end

    // NOTE: registers use non-blocking assignments so each one samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= INIT;
            board_q  <= '0;
            dir_q    <= DIR_UP;
            lfsr     <= SEED;
            line_cnt <= '0;
            moved_q  <= 1'b0;
            init_cnt <= 1'b0;
            win_q    <= 1'b0;
            over_q   <= 1'b0;
        end else begin
            state    <= state_next;
            board_q  <= board_next;
            dir_q    <= dir_next;
            lfsr     <= lfsr_next;
            line_cnt <= line_cnt_next;
            moved_q  <= moved_next;
            init_cnt <= init_cnt_next;
            win_q    <= win_next;
            over_q   <= over_next;
        end
    end

`ifdef BOARD_ENGINE_SCORE_EN
    function automatic logic [17:0] merge_score(input line_t in);
        logic [4:0][3:0] ext;
        logic [17:0]     sum;
        logic            skip;
        ext  = {4'd0, in};
        sum  = '0;
        skip = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (skip) begin
                skip = 1'b0;
            end else if (ext[i] != 4'd0 && ext[i] == ext[i+1]) begin
                sum  = sum + ((ext[i] == 4'd15) ? 18'h0FFFF : (18'd1 << (ext[i] + 4'd1)));
                skip = 1'b1;
            end
        end
        return sum;
    endfunction

    logic [15:0] score_q;
    logic [18:0] score_sum;

    assign score_sum = {3'b000, score_q} + {1'b0, merge_score(compress(line_in))};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            score_q <= '0;
        else if (state == SLIDE)
            score_q <= (score_sum > 19'h0FFFF) ? 16'hFFFF : score_sum[15:0];
    end

    assign score = score_q;
`else
    assign score = '0;
`endif

    assign board      = board_q;
    assign move_ready = (state == IDLE);
    assign done       = (state == CHECK);
    assign win        = win_q;
    assign game_over  = over_q;

endmodule
